// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: decode-stage register file with writeback bypass and a
// per-register in-flight write scoreboard that raises a RAW decode stall.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rs1D, rs2D                decode source addresses
//   usesrs1D, usesrs2D        decode instruction actually reads rs1 / rs2
//   rdD, regwriteD            decode destination and write enable
//   extstallD                 decode held by another source
//   flushE                    instruction leaving decode is squashed
//   resultW, rdW, regwriteW   writeback data, destination, enable
//   rd1D, rd2D                source operands (combinational, bypassed)
//   stallD                    RAW hazard stall (combinational)
//   a0                        content of x10 (not bypassed)
//   ovf                       sticky scoreboard overflow/underflow flag
module regfile_scoreboard #(
  parameter int unsigned W = 32,
  parameter int unsigned A = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [A-1:0] rs1D,
  input  logic [A-1:0] rs2D,
  input  logic         usesrs1D,
  input  logic         usesrs2D,
  input  logic [A-1:0] rdD,
  input  logic         regwriteD,
  input  logic         extstallD,
  input  logic         flushE,
  input  logic [W-1:0] resultW,
  input  logic [A-1:0] rdW,
  input  logic         regwriteW,
  output logic [W-1:0] rd1D,
  output logic [W-1:0] rd2D,
  output logic         stallD,
  output logic [W-1:0] a0,
  output logic         ovf
);

  localparam int unsigned N    = 1 << A;
  localparam int unsigned CW   = 2;
  localparam logic [CW-1:0] CMAX = CW'(3);
  localparam int unsigned A0_IDX = 10;

  logic [W-1:0]  regs_q [N];
  logic [W-1:0]  regs_d [N];
  logic [CW-1:0] cnt_q  [N];
  logic [CW-1:0] cnt_d  [N];
  logic          ovf_q, ovf_d;

  logic ret_c, iss_c;
  logic hit1_c, hit2_c;
  logic haz1_c, haz2_c;

  // Retire of a real register this cycle; also the register-file write enable.
  assign ret_c  = regwriteW && (rdW != '0);
  assign hit1_c = ret_c && (rdW == rs1D);
  assign hit2_c = ret_c && (rdW == rs2D);

  // Read ports: x0 is hard zero, a same-cycle writeback is bypassed.
  assign rd1D = (rs1D == '0) ? '0 : (hit1_c ? resultW : regs_q[rs1D]);
  assign rd2D = (rs2D == '0) ? '0 : (hit2_c ? resultW : regs_q[rs2D]);

  // Effective pending count excludes a retire happening now (bypass covers it).
  assign haz1_c = usesrs1D && (rs1D != '0) && (cnt_q[rs1D] != CW'(hit1_c));
  assign haz2_c = usesrs2D && (rs2D != '0) && (cnt_q[rs2D] != CW'(hit2_c));
  assign stallD = haz1_c | haz2_c;

  assign iss_c = regwriteD && (rdD != '0) && !stallD && !extstallD && !flushE;

  assign a0  = regs_q[A0_IDX];
  assign ovf = ovf_q;

  // Next-state: register write, counter issue/retire with saturation and error flag.
  always_comb begin
    logic inc;
    logic dec;
    regs_d = regs_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    inc    = 1'b0;
    dec    = 1'b0;
    if (ret_c) begin
      regs_d[rdW] = resultW;
    end
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < N; r++) begin
      inc = iss_c && (rdD == A'(r));
      dec = ret_c && (rdW == A'(r));
      if (inc && !dec) begin
        if (cnt_q[r] == CMAX) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CW'(1);
        end
      end else if (dec && !inc) begin
        if (cnt_q[r] == '0) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CW'(1);
        end
      end
    end
  end

  // State registers; reset discards any concurrent write, issue or retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < N; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      ovf_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios followed by
// random traffic, all compared against a behavioural model of the register
// file and pending-write counts.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1D, rs2D, rdD, rdW;
  logic        usesrs1D, usesrs2D, regwriteD, extstallD, flushE, regwriteW;
  logic [31:0] resultW;
  logic [31:0] rd1D, rd2D, a0;
  logic        stallD, ovf;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] mregs [32];
  int          mcnt  [32];
  bit          movf;
  bit          exp_stall;

  regfile_scoreboard #(.W(32), .A(5)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .usesrs1D(usesrs1D), .usesrs2D(usesrs2D),
    .rdD(rdD), .regwriteD(regwriteD), .extstallD(extstallD), .flushE(flushE),
    .resultW(resultW), .rdW(rdW), .regwriteW(regwriteW),
    .rd1D(rd1D), .rd2D(rd2D), .stallD(stallD), .a0(a0), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] rs);
    if (rs == 0) return 32'h0;
    if (regwriteW && rdW != 0 && rdW == rs) return resultW;
    return mregs[rs];
  endfunction

  function automatic bit mhaz(input bit use_it, input logic [4:0] rs);
    int eff;
    if (!use_it || rs == 0) return 1'b0;
    eff = mcnt[rs] - ((regwriteW && rdW != 0 && rdW == rs) ? 1 : 0);
    return eff != 0;
  endfunction

  task automatic idle();
    rst = 0; rs1D = 0; rs2D = 0; usesrs1D = 0; usesrs2D = 0;
    rdD = 0; regwriteD = 0; extstallD = 0; flushE = 0;
    resultW = 0; rdW = 0; regwriteW = 0;
  endtask

  // Settle inputs and compare all outputs against the model.
  task automatic eval(input string tag);
    #1;
    exp_stall = mhaz(usesrs1D, rs1D) | mhaz(usesrs2D, rs2D);
    chk({tag, ".rd1"}, rd1D, mread(rs1D));
    chk({tag, ".rd2"}, rd2D, mread(rs2D));
    chk({tag, ".stall"}, 32'(stallD), 32'(exp_stall));
    chk({tag, ".a0"}, a0, mregs[10]);
    chk({tag, ".ovf"}, 32'(ovf), 32'(movf));
  endtask

  // Advance one clock and update the model with the same inputs.
  task automatic tick();
    bit ret, iss;
    int n;
    exp_stall = mhaz(usesrs1D, rs1D) | mhaz(usesrs2D, rs2D);
    ret = regwriteW && rdW != 0;
    iss = regwriteD && rdD != 0 && !exp_stall && !extstallD && !flushE;
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < 32; r++) begin mregs[r] = 0; mcnt[r] = 0; end
      movf = 0;
    end else begin
      if (ret) mregs[rdW] = resultW;
      for (int r = 1; r < 32; r++) begin
        n = mcnt[r] + ((iss && rdD == r) ? 1 : 0) - ((ret && rdW == r) ? 1 : 0);
        if (n > 3) begin movf = 1; n = 3; end
        if (n < 0) begin movf = 1; n = 0; end
        mcnt[r] = n;
      end
    end
    @(negedge clk);
  endtask

  task automatic cyc(input string tag);
    eval(tag);
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick();
    idle();

    // Reset clears registers, counters and ovf
    regwriteD = 1; rdD = 5; cyc("rst_iss");
    idle(); regwriteW = 1; rdW = 5; resultW = 32'hDEADBEEF; cyc("rst_wr");
    idle(); rst = 1; cyc("rst_pulse");
    idle(); rs1D = 5; usesrs1D = 1; eval("rst_chk");
    chk("rst_rd1_zero", rd1D, 32'h0);
    chk("rst_stall_zero", 32'(stallD), 32'h0);
    chk("rst_a0_zero", a0, 32'h0);
    chk("rst_ovf_zero", 32'(ovf), 32'h0);
    tick();

    // Bypass and x0
    idle(); regwriteD = 1; rdD = 7; cyc("byp_iss7");
    idle(); regwriteD = 1; rdD = 10; cyc("byp_iss10");
    idle(); regwriteW = 1; rdW = 7; resultW = 32'h12345678; rs1D = 7; rs2D = 0; eval("byp");
    chk("byp_rd1", rd1D, 32'h12345678);
    chk("byp_rd2_x0", rd2D, 32'h0);
    tick();
    idle(); regwriteW = 1; rdW = 0; resultW = 32'hFFFFFFFF; rs2D = 0; cyc("x0_wr");
    idle(); regwriteW = 1; rdW = 10; resultW = 32'h0000A0A0; rs1D = 7; eval("a0_wr");
    chk("a0_not_bypassed", a0, 32'h0);
    chk("x7_from_array", rd1D, 32'h12345678);
    tick();
    idle(); rs2D = 0; eval("a0_next");
    chk("a0_updated", a0, 32'h0000A0A0);
    chk("x0_stays_zero", rd2D, 32'h0);
    tick();

    // RAW stall on x3
    idle(); regwriteD = 1; rdD = 3; cyc("raw_iss");
    idle(); usesrs1D = 1; rs1D = 3; eval("raw_c1");
    chk("raw_stall_c1", 32'(stallD), 32'h1);
    tick();
    eval("raw_c2");
    chk("raw_stall_c2", 32'(stallD), 32'h1);
    tick();
    regwriteW = 1; rdW = 3; resultW = 32'hCAFE0003; eval("raw_wb");
    chk("raw_release", 32'(stallD), 32'h0);
    chk("raw_bypass", rd1D, 32'hCAFE0003);
    tick();

    // Double pending on x4
    idle(); regwriteD = 1; rdD = 4; cyc("dbl_iss1");
    cyc("dbl_iss2");
    idle(); usesrs2D = 1; rs2D = 4; eval("dbl_rd");
    chk("dbl_stall", 32'(stallD), 32'h1);
    tick();
    regwriteW = 1; rdW = 4; resultW = 32'h44; eval("dbl_ret1");
    chk("dbl_stall_ret1", 32'(stallD), 32'h1);
    tick();
    regwriteW = 1; rdW = 4; resultW = 32'h444; eval("dbl_ret2");
    chk("dbl_clear_ret2", 32'(stallD), 32'h0);
    chk("dbl_bypass", rd2D, 32'h444);
    tick();

    // Flush suppresses the increment
    idle(); regwriteD = 1; rdD = 9; flushE = 1; cyc("fl_iss");
    idle(); usesrs1D = 1; rs1D = 9; eval("fl_rd");
    chk("fl_no_stall", 32'(stallD), 32'h0);
    tick();

    // External stall also suppresses the increment
    idle(); regwriteD = 1; rdD = 11; extstallD = 1; cyc("ext_iss");
    idle(); usesrs1D = 1; rs1D = 11; eval("ext_rd");
    chk("ext_no_stall", 32'(stallD), 32'h0);
    tick();

    // Overflow: fourth issue to x8
    for (int i = 0; i < 4; i++) begin
      idle(); regwriteD = 1; rdD = 8; cyc("ovf_iss");
    end
    idle(); eval("ovf_chk");
    chk("ovf_set", 32'(ovf), 32'h1);
    tick();
    idle(); rst = 1; cyc("ovf_rst");
    idle(); eval("ovf_cleared");
    chk("ovf_cleared", 32'(ovf), 32'h0);
    tick();

    // Underflow: retire x6 with nothing pending
    idle(); regwriteW = 1; rdW = 6; resultW = 32'h66; eval("unf_ret");
    chk("unf_not_yet", 32'(ovf), 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      idle(); usesrs1D = 1; rs1D = 6; eval("unf_hold");
      chk("unf_sticky", 32'(ovf), 32'h1);
      chk("unf_cnt_zero", 32'(stallD), 32'h0);
      tick();
    end
    idle(); rst = 1; cyc("unf_rst");

    // Random traffic with mostly legal retires
    for (int i = 0; i < 600; i++) begin
      idle();
      rs1D = 5'($urandom_range(0, 31));
      rs2D = 5'($urandom_range(0, 31));
      usesrs1D = 1'($urandom);
      usesrs2D = 1'($urandom);
      regwriteD = ($urandom_range(0, 2) != 0);
      rdD = 5'($urandom_range(0, 31));
      extstallD = ($urandom_range(0, 7) == 0);
      flushE = ($urandom_range(0, 7) == 0);
      regwriteW = 1'($urandom);
      resultW = $urandom;
      rdW = 5'($urandom_range(0, 31));
      if (regwriteW && mcnt[rdW] == 0 && $urandom_range(0, 15) != 0) begin
        for (int k = 0; k < 32; k++) begin
          if (mcnt[(int'(rdW) + k) % 32] != 0) begin
            rdW = 5'((int'(rdW) + k) % 32);
            break;
          end
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
